// File: rtl/cabac_pkg.sv
// Shared CABAC context types: address split, context-state layout and the
// LPS state-transition table used by the context updater.
package cabac_pkg;

    localparam int unsigned CTX_BANK_W = 3;
    localparam int unsigned CTX_IDX_W  = 5;
    localparam int unsigned CTX_ADDR_W = CTX_BANK_W + CTX_IDX_W;
    localparam int unsigned CTX_PIDX_W = 6;

    // First address that is never stored; everything at or above it is rejected
    localparam logic [CTX_ADDR_W-1:0] CTX_ADDR_INVALID = 8'hBF;

    // MPS path saturates here; 63 is a terminal state that never moves
    localparam logic [CTX_PIDX_W-1:0] CTX_PIDX_MPS_MAX = 6'd62;

    typedef struct packed {
        logic [CTX_PIDX_W-1:0] pidx;
        logic                  mps;
    } ctx_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } ctx_fsm_t;

    localparam logic [CTX_PIDX_W-1:0] TRANS_IDX_LPS [64] = '{
        6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
        6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
        6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
        6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
        6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
        6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
        6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
        6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
    };

    function automatic logic [CTX_PIDX_W-1:0] trans_idx_lps(input logic [CTX_PIDX_W-1:0] pidx);
        return TRANS_IDX_LPS[pidx];
    endfunction

endpackage

// File: rtl/cabac_ctx_state_rw_if.sv
// Bin-request / context-state response bus between binarizer and context store.
interface cabac_ctx_state_rw_if;
    import cabac_pkg::*;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [CTX_ADDR_W-1:0] req_addr_i;
    logic                  req_bin_i;
    logic                  state_valid_o;
    logic [CTX_PIDX_W-1:0] state_pidx_o;
    logic                  state_mps_o;
    logic                  err_o;

    modport master (
        output req_valid_i, req_addr_i, req_bin_i,
        input  req_ready_o, state_valid_o, state_pidx_o, state_mps_o, err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_bin_i,
        output req_ready_o, state_valid_o, state_pidx_o, state_mps_o, err_o
    );

endinterface

// File: rtl/cabac_ctx_trans.sv
// Combinational context-state transition after coding one bin.
module cabac_ctx_trans
    import cabac_pkg::*;
(
    input  ctx_state_t cur_state,
    input  logic       bin,
    output ctx_state_t state_nxt_c
);

    always_comb begin
        state_nxt_c = cur_state;
        if (bin == cur_state.mps) begin
            // 62 saturates, 63 is terminal; both fail this compare and hold
            if (cur_state.pidx < CTX_PIDX_MPS_MAX) begin
                state_nxt_c.pidx = cur_state.pidx + 6'd1;
            end
        end else begin
            state_nxt_c.pidx = trans_idx_lps(cur_state.pidx);
            if (cur_state.pidx == '0) begin
                state_nxt_c.mps = ~cur_state.mps;
            end
        end
    end

endmodule

// File: rtl/cabac_ctx_state_rw.sv
// CABAC context-state store: slice-start init from an external table, then a
// two-stage read/update/write-back pipeline with S2->S1 forwarding.
module cabac_ctx_state_rw
    import cabac_pkg::*;
#(
    parameter int unsigned NUM_BANK   = 6,
    parameter int unsigned BANK_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_start_i,
    output logic [CTX_ADDR_W-1:0] init_addr_o,
    input  logic [CTX_PIDX_W:0]   init_data_i,
    output logic                  init_done_o,
    cabac_ctx_state_rw_if.slave   bus
);

    localparam int unsigned DEPTH = NUM_BANK * BANK_DEPTH;
    localparam logic [CTX_ADDR_W-1:0] LAST_ADDR = CTX_ADDR_W'(DEPTH - 1);

    ctx_fsm_t              state;
    ctx_state_t            ctx_mem [DEPTH];

    logic                  s2_valid;
    logic                  s2_err;
    logic                  s2_bin;
    logic [CTX_ADDR_W-1:0] s2_addr;
    ctx_state_t            s2_state;
    ctx_state_t            s2_nxt_c;
    logic                  err_q;

    logic                  init_wr;
    logic [CTX_ADDR_W-1:0] init_wr_addr;

    logic                  accept_c;
    logic                  addr_bad_c;
    logic [CTX_ADDR_W-1:0] rd_idx_c;
    ctx_state_t            rd_state_c;
    ctx_state_t            s1_state_c;
    logic                  s2_wr_c;
    logic                  fwd_c;
    logic                  init_last_wr_c;

    assign bus.req_ready_o   = (state == ST_RUN);
    assign bus.state_valid_o = s2_valid;
    assign bus.state_pidx_o  = s2_state.pidx;
    assign bus.state_mps_o   = s2_state.mps;
    assign bus.err_o         = err_q;

    // S1: read the entry, replacing it with S2's result when S2 targets the same context
    always_comb begin
        accept_c       = bus.req_valid_i && (state == ST_RUN);
        addr_bad_c     = (bus.req_addr_i >= CTX_ADDR_INVALID);
        rd_idx_c       = addr_bad_c ? '0 : bus.req_addr_i;
        rd_state_c     = ctx_mem[rd_idx_c];
        s2_wr_c        = s2_valid && !s2_err;
        fwd_c          = s2_wr_c && (s2_addr == bus.req_addr_i);
        s1_state_c     = fwd_c ? s2_nxt_c : rd_state_c;
        init_last_wr_c = init_wr && (init_wr_addr == LAST_ADDR);
    end

    cabac_ctx_trans u_trans (
        .cur_state   (s2_state),
        .bin         (s2_bin),
        .state_nxt_c (s2_nxt_c)
    );

    // Control FSM, init address walker and S2 pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            init_addr_o  <= '0;
            init_done_o  <= 1'b0;
            init_wr      <= 1'b0;
            init_wr_addr <= '0;
            s2_valid     <= 1'b0;
            s2_err       <= 1'b0;
            s2_bin       <= 1'b0;
            s2_addr      <= '0;
            s2_state     <= '0;
            err_q        <= 1'b0;
        end else begin
            init_done_o <= 1'b0;
            init_wr     <= 1'b0;

            unique case (state)
                ST_IDLE, ST_RUN: begin
                    if (init_start_i) begin
                        state       <= ST_INIT;
                        init_addr_o <= '0;
                    end
                end
                ST_INIT: begin
                    // Table data trails its address by one cycle, so the write lags the walk
                    init_wr      <= 1'b1;
                    init_wr_addr <= init_addr_o;
                    if (init_addr_o != LAST_ADDR) begin
                        init_addr_o <= init_addr_o + 8'd1;
                    end
                    init_done_o <= (init_addr_o == LAST_ADDR) && !init_last_wr_c;
                    if (init_last_wr_c) begin
                        state       <= ST_RUN;
                        init_addr_o <= '0;
                        init_wr     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            s2_valid <= accept_c;
            err_q    <= accept_c && addr_bad_c;
            if (accept_c) begin
                s2_addr  <= bus.req_addr_i;
                s2_bin   <= bus.req_bin_i;
                s2_err   <= addr_bad_c;
                s2_state <= addr_bad_c ? ctx_state_t'('0) : s1_state_c;
            end
        end
    end

    // Single write port: pipeline write-back and init writes never overlap in time
    always_ff @(posedge clk) begin
        if (s2_wr_c) begin
            ctx_mem[s2_addr] <= s2_nxt_c;
        end else if (init_wr) begin
            ctx_mem[init_wr_addr] <= ctx_state_t'(init_data_i);
        end
    end

endmodule

// File: tb/tb_cabac_ctx_state_rw.sv
// Randomized scoreboard bench for cabac_ctx_state_rw against a per-context
// array model of pStateIdx/valMPS.
module tb_cabac_ctx_state_rw;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_start_i = 1'b0;
    logic [7:0] init_addr_o;
    logic [6:0] init_data_i = '0;
    logic       init_done_o;

    cabac_ctx_state_rw_if bus ();

    cabac_ctx_state_rw #(.NUM_BANK(6), .BANK_DEPTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_start_i (init_start_i),
        .init_addr_o  (init_addr_o),
        .init_data_i  (init_data_i),
        .init_done_o  (init_done_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int lps_tab [64] = '{
        0, 0, 1, 2, 2, 4, 4, 5, 6, 7, 8, 9, 9, 11, 11, 12,
        13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
        24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
        33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
    };

    logic [6:0] init_tab [192];
    int         m_pidx [192];
    bit         m_mps [192];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected response for one accepted request, then advance the context model
    task automatic push_expect(input logic [7:0] a, input bit b);
        int i;
        if (a >= 8'd191) begin
            exp_q.push_back({1'b1, 6'd0, 1'b0});
        end else begin
            i = int'(a);
            exp_q.push_back({1'b0, 6'(m_pidx[i]), m_mps[i]});
            if (b == m_mps[i]) begin
                if (m_pidx[i] < 62) m_pidx[i] = m_pidx[i] + 1;
            end else begin
                if (m_pidx[i] == 0) m_mps[i] = ~m_mps[i];
                m_pidx[i] = lps_tab[m_pidx[i]];
            end
        end
    endtask

    task automatic issue(input logic [7:0] a, input bit b);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_bin_i   = b;
        if (bus.req_ready_o) push_expect(a, b);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Pulse init (optionally with a same-cycle request) and check the full walk timing
    task automatic do_init(input bit with_req, input logic [7:0] ra, input bit rb);
        init_start_i = 1'b1;
        if (with_req) begin
            check("init_req_ready", 32'(bus.req_ready_o), 32'd1);
            issue(ra, rb);
        end else begin
            @(posedge clk); #1;
        end
        init_start_i    = 1'b0;
        bus.req_valid_i = 1'b0;
        for (int k = 1; k <= 194; k++) begin
            if (k <= 192) check("init_addr", 32'(init_addr_o), 32'(k - 1));
            check("init_done", 32'(init_done_o), 32'(k == 193));
            check("init_ready", 32'(bus.req_ready_o), 32'(k == 194));
            if (k != 194) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < 192; i++) begin
            m_pidx[i] = int'(init_tab[i][6:1]);
            m_mps[i]  = init_tab[i][0];
        end
    endtask

    // External init table: returns data for the address shown in the previous cycle
    initial begin
        logic [7:0] prev;
        prev = '0;
        forever begin
            @(posedge clk); #1;
            init_data_i = (prev < 8'd192) ? init_tab[prev] : 7'd0;
            prev = init_addr_o;
        end
    end

    // Monitor: every valid response must match the oldest expectation
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.state_valid_o) begin
                    check("sb_occupied", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("state_resp", 32'({bus.err_o, bus.state_pidx_o, bus.state_mps_o}), 32'(e));
                    end
                end else begin
                    check("err_without_valid", 32'(bus.err_o), 32'd0);
                end
            end
        end
    end

    initial begin
        int waited;
        int dones;
        logic [7:0] a;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_bin_i   = 1'b0;
        for (int i = 0; i < 192; i++) init_tab[i] = 7'h15;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_valid", 32'(bus.state_valid_o), 32'd0);
        check("rst_pidx", 32'(bus.state_pidx_o), 32'd0);
        check("rst_mps", 32'(bus.state_mps_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_done", 32'(init_done_o), 32'd0);
        check("rst_init_addr", 32'(init_addr_o), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("idle_ready", 32'(bus.req_ready_o), 32'd0);

        // Uniform table {10,1}; then back-to-back MPS/MPS/LPS on {0,4}
        do_init(1'b0, 8'd0, 1'b0);
        issue({3'd3, 5'd31}, 1'b1);
        issue({3'd0, 5'd4}, 1'b1);
        issue({3'd0, 5'd4}, 1'b1);
        issue({3'd0, 5'd4}, 1'b0);
        issue({3'd0, 5'd4}, 1'b1);
        idle(2);

        // Random table with corner entries: LPS at 0, MPS at 62 and terminal 63
        for (int i = 0; i < 192; i++) init_tab[i] = 7'($urandom_range(0, 127));
        init_tab[1] = {6'd0, 1'b1};
        init_tab[2] = {6'd62, 1'b1};
        init_tab[3] = {6'd63, 1'b0};
        do_init(1'b0, 8'd0, 1'b0);
        issue(8'd1, 1'b0);
        issue(8'd1, 1'b0);
        issue(8'd1, 1'b0);
        issue(8'd2, 1'b1);
        issue(8'd2, 1'b1);
        issue(8'd3, 1'b0);
        issue(8'd3, 1'b1);
        issue(8'd3, 1'b0);

        // Invalid addresses interleaved with a neighbour to catch stray writes/forwarding
        issue(8'd190, 1'b1);
        issue(8'hBF, 1'b1);
        issue(8'd190, 1'b0);
        issue({3'd6, 5'd0}, 1'b0);
        issue(8'hFF, 1'b1);
        issue(8'd190, 1'b1);
        issue(8'd189, 1'b0);
        idle(2);

        // Re-init from RUN with a request accepted in the same cycle
        for (int i = 0; i < 192; i++) init_tab[i] = 7'($urandom_range(0, 127));
        do_init(1'b1, {3'd2, 5'd2}, 1'b1);
        issue({3'd2, 5'd2}, 1'b0);
        issue({3'd2, 5'd2}, 1'b1);
        idle(2);

        // Reset in the middle of init
        init_start_i = 1'b1;
        @(posedge clk); #1;
        init_start_i = 1'b0;
        waited = 0;
        while (init_addr_o != 8'd100 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_entry_100", 32'(init_addr_o), 32'd100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", 32'(bus.req_ready_o), 32'd0);
        check("midrst_done", 32'(init_done_o), 32'd0);
        check("midrst_init_addr", 32'(init_addr_o), 32'd0);
        check("midrst_valid", 32'(bus.state_valid_o), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (init_done_o) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_still_idle", 32'(bus.req_ready_o), 32'd0);

        // Fresh init and randomized traffic with a hot address set for forwarding
        for (int i = 0; i < 192; i++) init_tab[i] = 7'($urandom_range(0, 127));
        do_init(1'b0, 8'd0, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      a = 8'($urandom_range(0, 3));
            else if (r < 5) a = 8'($urandom_range(191, 255));
            else            a = 8'($urandom_range(0, 190));
            if ($urandom_range(0, 4) != 0) begin
                issue(a, 1'($urandom_range(0, 1)));
            end else begin
                bus.req_addr_i = a;
                idle(1);
            end
        end
        idle(4);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cabac_ctx_state_rw.md
# cabac_ctx_state_rw

Context-state store and updater for the CABAC encoder. It consumes the 8-bit `{bank, index}` context addresses produced by the binarizer's context-selection logic and returns the current `{pStateIdx, valMPS}` to the binary arithmetic engine. It then writes the post-coding state back to storage. The block sits between binarization and the BAE, and also owns slice-start context initialization.

## Interface
- `NUM_BANK`, default 6: valid banks are 0..5.
- `BANK_DEPTH`, default 32: entries per bank (index 0..31).
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `init_start_i` input 1: pulse; starts full context initialization.
- `init_addr_o` output 8: `{bank[2:0], idx[4:0]}` of the entry being fetched from the external init table.
- `init_data_i` input 7: `{pStateIdx[5:0], valMPS}` for `init_addr_o` of the previous cycle.
- `init_done_o` output 1: one-cycle pulse when the last entry has been written.
- `req_valid_i` input 1: bin request.
- `req_ready_o` output 1: high only in RUN.
- `req_addr_i` input 8: `{bank, idx}` context address.
- `req_bin_i` input 1: bin value being coded.
- `state_valid_o` output 1: state output valid.
- `state_pidx_o` output 6: pStateIdx before update.
- `state_mps_o` output 1: valMPS before update.
- `err_o` output 1: one-cycle pulse marking an invalid-address request.

## Operation
- **FSM states:** IDLE, INIT, RUN.
  - After reset the FSM is in IDLE, with `req_ready_o`=0.
  - `init_start_i` in IDLE or RUN moves the FSM to INIT.
  - At the end of INIT the FSM moves to RUN. `init_start_i` is ignored while in INIT.
- **INIT:**
  - An 8-bit counter walks addresses bank 0..5, idx 0..31, 192 entries in total, driving `init_addr_o`.
  - `init_data_i` is written one cycle later to the previous address.
  - After the write of `{5,31}`, `init_done_o` pulses and the FSM moves to RUN.
  - Entries are not accessed by requests during INIT.
- **RUN pipeline:**
  - **S1 (accept cycle):** capture the address and bin. Read the entry. If S2 holds the same valid address, forward S2's updated state instead of the stored value.
  - **S2:**
    - Register the state onto the `state_*` outputs and raise `state_valid_o`.
    - Compute the next state and write it back at the end of this cycle.
- **Next state:**
  - `bin == valMPS`: pidx = min(pidx+1, 62). If pidx is 63 it stays 63.
  - `bin != valMPS`: pidx = transIdxLps[pidx]. If pidx was 0, valMPS inverts.
- **Invalid address (bank ≥ 6, or `{5,31}`):**
  - The request is accepted.
  - In S2: `state_valid_o`=1, `state_pidx_o`=0, `state_mps_o`=0, `err_o`=1.
  - No write-back, and nothing is forwarded from this request.
- **Throughput:** one request per cycle, with no stalls in RUN. Back-to-back requests to the same address see each other's update.
- **`init_start_i` while in RUN:** a request accepted in the same cycle is still processed. Its write-back completes before the first init write, which lands 2 cycles later.
- **Reset:** reset at any time, including mid-INIT or mid-pipeline, returns the FSM to IDLE and clears the pipeline valids. Storage contents are then undefined until the next INIT.

## Timing
- **Reset values:** `req_ready_o`=0, `state_valid_o`=0, `state_pidx_o`=0, `state_mps_o`=0, `err_o`=0, `init_done_o`=0, `init_addr_o`=0.
- **Request latency:** request accepted at cycle t → `state_*` valid at t+1, and the write-back takes effect at the t+1 clock edge.
- **INIT duration:** `init_start_i` sampled at cycle t:
  - `init_addr_o`=0 at t+1.
  - Last address `{5,31}` at t+192.
  - `init_done_o` at t+193, with `req_ready_o`=1 from t+194.
- **Init table latency:** `init_data_i` is sampled exactly 1 cycle after its address.
- **Outputs:** all registered except `req_ready_o`, which is decoded from the FSM state.

## Structure
- **Shared package `cabac_pkg`:**
  - `CTX_BANK_W`=3 and `CTX_IDX_W`=5.
  - Context-state type `{pidx[5:0], mps}`.
  - The 64-entry transIdxLps constant.
  - `CTX_ADDR_INVALID` = 8'hBF.
- **Sub-module `cabac_ctx_trans`:** combinational next-state (pidx, mps, bin → pidx', mps'). It is shared with any future bit-rate estimator.
- **Storage:** a register array, 192×7 bits.

## Test plan
1. **Init:** init table = `{pidx 10, mps 1}` everywhere; pulse `init_start_i` → `init_done_o` exactly 193 cycles later; reading `{3,31}` with bin=1 gives state 10/1.
2. **Back-to-back MPS/LPS:** init as in (1), then `{0,4}` with bin 1, then `{0,4}` with bin 1 on consecutive cycles → outputs 10/1 then 11/1 (forwarded). A third request with bin 0 → 12/1, and the stored result is 9/1 (transIdxLps[12]=9).
3. **LPS at pidx 0:** init `{0,1}` to 0/1, apply bin 0 twice → outputs 0/1 then 0/0. MPS at 62: bin=mps keeps 62.
4. **Invalid addresses:** `8'hBF`, then `{6,0}` → `err_o` pulses on both, state outputs 0, and neighbouring entries are unchanged.
5. **Init from RUN:** request on `{2,2}` in the same cycle as `init_start_i` → state returned at t+1; after init completes, `{2,2}` reads the init value.
6. **Reset mid-init:** `rst_n`=0 at init entry 100 → next cycle IDLE, ready 0, no `init_done_o`; re-init completes normally.
